uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : state encoding and frame constants shared by UART blocks.     |
// | Optional feature macro: UART_TX_PARITY_EN (adds PARITY state + 1 bit).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_fifo : power-of-two circular transmit buffer with level count.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the level/pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx : buffered 8N1 serial transmitter (8E1 with UART_TX_PARITY_EN).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t       state, state_nxt;
    logic [BAUD_W-1:0] baud, baud_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [7:0]        data_q, data_nxt;
    logic              ser_nxt;
    logic              ready_en;
    logic              push, pop, full, empty, bit_end;
    logic [7:0]        pop_data;
    logic [2:0]        next_bit;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    // ready_en keeps tx_ready low through reset and for the first edge after it.
    assign tx_ready = ready_en && !full;
    assign push     = tx_valid && tx_ready;
    assign busy     = (state != ST_IDLE) || !empty;
    assign bit_end  = (baud == BAUD_LAST);
    assign next_bit = bit_cnt + 3'd1;

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        data_nxt  = data_q;
        ser_nxt   = ser_tx;
        pop       = 1'b0;
        baud_nxt  = (state == ST_IDLE || bit_end) ? '0 : baud + 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    data_nxt  = pop_data;
                    state_nxt = ST_START;
                    ser_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = 3'd0;
                    ser_nxt   = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
                        ser_nxt   = even_parity(data_q);
`else
                        state_nxt = ST_STOP;
                        ser_nxt   = 1'b1;
`endif
                    end else begin
                        bit_nxt = next_bit;
                        ser_nxt = data_q[next_bit];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                    ser_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Pop straight into the next start bit so frames stay contiguous.
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        data_nxt  = pop_data;
                        state_nxt = ST_START;
                        ser_nxt   = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                        ser_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ser_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud     <= '0;
            bit_cnt  <= 3'd0;
            data_q   <= 8'd0;
            ser_tx   <= 1'b1;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud     <= baud_nxt;
            bit_cnt  <= bit_nxt;
            data_q   <= data_nxt;
            ser_tx   <= ser_nxt;
            ready_en <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx : directed self-checking bench for uart_tx (CLKS_PER_BIT=5).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_tx;
    localparam int CPB   = 5;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ser_tx;
    logic       busy;
    logic [3:0] fifo_level;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one byte until accepted; stalls counts edges where it was refused.
    task automatic push(input logic [7:0] b, output int stalls);
        logic acc;
        logic done;
        stalls = 0;
        done   = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            acc = tx_ready;
            step(1);
            if (acc) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        tx_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Waits for a start bit, then requires every bit held exactly CPB cycles.
    task automatic expect_frame(input logic [7:0] b, input string tag, output int gap);
        logic [10:0] fr;
        logic [10:0] obs;
        logic        e;
        logic        o;
        gap = 0;
        while (ser_tx !== 1'b0 && gap < 300) begin
            step(1);
            gap++;
        end
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
`else
        fr = {1'b0, 1'b1, b, 1'b0};
`endif
        obs = fr;
        for (int i = 0; i < FRAME_LEN; i++) begin
            e = fr[i];
            o = e;
            for (int c = 0; c < CPB; c++) begin
                if (ser_tx !== e) o = ser_tx;
                step(1);
            end
            obs[i] = o;
        end
        check(tag, 32'(obs), 32'(fr));
    endtask

    // Mid-bit sampling receiver, independent of exact bit timing.
    task automatic rx_sample(output logic [7:0] b);
        int w;
        w = 0;
        b = 8'h00;
        while (ser_tx !== 1'b0 && w < 300) begin
            step(1);
            w++;
        end
        step(CPB / 2);
        check("rx_start_mid", 32'(ser_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(CPB);
            b[i] = ser_tx;
        end
        step(CPB);
        check("rx_stop_mid", 32'(ser_tx), 32'd1);
    endtask

    logic [7:0] seq [10] = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'hFF,
                             8'h00, 8'h96, 8'h69, 8'hA5, 8'h5A};

    initial begin
        int g;
        int s;
        int t0;
        logic [7:0] rb;

        // Reset state
        step(3);
        check("rst_ser", 32'(ser_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(tx_ready), 32'd0);
        step(1);
        check("ready_after_release", 32'(tx_ready), 32'd1);

        // Data without valid is ignored
        tx_data = 8'hFF;
        step(3);
        check("novalid_level", 32'(fifo_level), 32'd0);
        check("novalid_ser", 32'(ser_tx), 32'd1);

        // Single byte 0x55 from idle
        push(8'h55, s);
        check("p55_level", 32'(fifo_level), 32'd1);
        check("p55_busy", 32'(busy), 32'd1);
        check("p55_ser_pre", 32'(ser_tx), 32'd1);
        expect_frame(8'h55, "frame_55", g);
        check("p55_latency", 32'(g), 32'd1);
        check("p55_idle_ser", 32'(ser_tx), 32'd1);
        check("p55_idle_busy", 32'(busy), 32'd0);

        // Back-to-back 0x41, 0x0A
        push(8'h41, s);
        push(8'h0A, s);
        check("b2b_level", 32'(fifo_level), 32'd1);
        t0 = cyc;
        expect_frame(8'h41, "frame_41", g);
        check("b2b_gap0", 32'(g), 32'd0);
        check("b2b_busy_mid", 32'(busy), 32'd1);
        expect_frame(8'h0A, "frame_0A", g);
        check("b2b_gap1", 32'(g), 32'd0);
        check("b2b_cycles", 32'(cyc - t0), 32'd100);
        check("b2b_busy_end", 32'(busy), 32'd0);

        // Fill beyond capacity; refused byte waits for the first pop
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    push(seq[i], s);
                    check("fill_nostall", 32'(s), 32'd0);
                end
                check("full_level", 32'(fifo_level), 32'd8);
                check("full_ready", 32'(tx_ready), 32'd0);
                push(seq[9], s);
                check("full_stalls", 32'(s), 32'd43);
                check("refill_level", 32'(fifo_level), 32'd8);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    expect_frame(seq[i], "order_frame", g);
                    if (i == 0) check("order_first_gap", 32'(g), 32'd2);
                    else        check("order_gap", 32'(g), 32'd0);
                end
            end
        join
        check("order_busy_end", 32'(busy), 32'd0);
        check("order_level_end", 32'(fifo_level), 32'd0);

        // Reset during data bit 3
        push(8'hF0, s);
        push(8'h33, s);
        check("mid_start", 32'(ser_tx), 32'd0);
        step(22);
        check("mid_bit3", 32'(ser_tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ser", 32'(ser_tx), 32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd0);
        step(2);
        #2;
        rst_n = 1'b1;
        step(1);
        check("mid_ready_back", 32'(tx_ready), 32'd1);
        push(8'h5A, s);
        expect_frame(8'h5A, "mid_clean_frame", g);
        check("mid_clean_latency", 32'(g), 32'd1);
        step(60);
        check("mid_no_stale_ser", 32'(ser_tx), 32'd1);
        check("mid_no_stale_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity of 0x07 is 1; frame is 11 bits long
        push(8'h07, s);
        step(1);
        t0 = cyc;
        expect_frame(8'h07, "parity_frame_07", g);
        check("parity_cycles", 32'(cyc - t0), 32'd55);
        check("parity_idle", 32'(busy), 32'd0);
`else
        // Loopback of "AB\n" through a mid-bit receiver
        fork
            begin
                push(8'h41, s);
                push(8'h42, s);
                push(8'h0A, s);
            end
            begin
                rx_sample(rb);
                check("loop_A", 32'(rb), 32'h41);
                rx_sample(rb);
                check("loop_B", 32'(rb), 32'h42);
                rx_sample(rb);
                check("loop_nl", 32'(rb), 32'h0A);
            end
        join
        step(10);
        check("loop_idle", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
